// File: rtl/score_display_if.sv
`default_nettype none
// ============================================================================
// Module      : score_display_if
// Description : Score input and display/status outputs of score_display.
// Revision    : 1.0 - initial release
// ============================================================================
interface score_display_if;
    logic [31:0] score;
    logic [15:0] bcd;
    logic        busy;
    logic        overflow;
    logic [3:0]  an;
    logic [6:0]  seg;

    modport master (output score, input bcd, busy, overflow, an, seg);
    modport slave  (input score, output bcd, busy, overflow, an, seg);
endinterface
`default_nettype wire

// File: rtl/score_display.sv
`default_nettype none
// ============================================================================
// Module      : score_display
// Description : Score-to-BCD converter (shift-add-3) with a muxed 4-digit
//               active-low 7-segment driver.
// Revision    : 1.0 - initial release
// ============================================================================
module score_display #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 25000,
    parameter int BLANK_LZ    = 1
) (
    input  logic           clk,
    input  logic           resetn,
    score_display_if.slave bus
);
    localparam int              BW          = 4 * DIGITS;
    localparam int              CW          = $clog2(REFRESH_DIV);
    localparam int              IW          = $clog2(DIGITS);
    localparam logic [CW-1:0]   c_cnt_max   = CW'(REFRESH_DIV - 1);
    localparam logic [31:0]     c_max_score = 32'd9999;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [31:0]    shadow_q, shadow_d;
    logic [13:0]    work_q, work_d;
    logic [BW-1:0]  acc_q, acc_d, adj;
    logic [3:0]     bitcnt_q, bitcnt_d;
    logic           ovf_pend_q, ovf_pend_d;
    logic [BW-1:0]  bcd_q, bcd_d;
    logic           busy_q, busy_d;
    logic           ovf_q, ovf_d;

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d, idx_nxt;
    logic [DIGITS-1:0] an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic [3:0]        digit;
    logic              blank;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'h40;
            4'd1:    seg_of = 7'h79;
            4'd2:    seg_of = 7'h24;
            4'd3:    seg_of = 7'h30;
            4'd4:    seg_of = 7'h19;
            4'd5:    seg_of = 7'h12;
            4'd6:    seg_of = 7'h02;
            4'd7:    seg_of = 7'h78;
            4'd8:    seg_of = 7'h00;
            4'd9:    seg_of = 7'h10;
            default: seg_of = 7'h7F;
        endcase
    endfunction

    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        work_d     = work_q;
        acc_d      = acc_q;
        bitcnt_d   = bitcnt_q;
        ovf_pend_d = ovf_pend_q;
        bcd_d      = bcd_q;
        busy_d     = busy_q;
        ovf_d      = ovf_q;
        adj        = acc_q;
        case (state_q)
            IDLE: begin
                if (bus.score != shadow_q) begin
                    shadow_d   = bus.score;
                    work_d     = (bus.score > c_max_score) ? 14'd9999 : bus.score[13:0];
                    ovf_pend_d = (bus.score > c_max_score);
                    acc_d      = '0;
                    bitcnt_d   = '0;
                    busy_d     = 1'b1;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                // Double-dabble step: correct nibbles >= 5, then shift in the next binary bit.
                for (int n = 0; n < DIGITS; n++) begin
                    adj[4*n +: 4] = (acc_q[4*n +: 4] >= 4'd5) ? acc_q[4*n +: 4] + 4'd3
                                                              : acc_q[4*n +: 4];
                end
                {acc_d, work_d} = {adj, work_q} << 1;
                bitcnt_d        = bitcnt_q + 4'd1;
                if (bitcnt_q == 4'd13) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_d   = acc_q;
                ovf_d   = ovf_pend_q;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = (cnt_q == c_cnt_max) ? '0 : cnt_q + 1'b1;
        idx_d   = idx_q;
        an_d    = an_q;
        seg_d   = seg_q;
        idx_nxt = idx_q + 1'b1;
        digit   = bcd_q[4*idx_nxt +: 4];
        // A non-ones digit is blank only when it and every digit above it are zero.
        blank   = (BLANK_LZ != 0) && (idx_nxt != '0);
        for (int k = 1; k < DIGITS; k++) begin
            if ((k >= int'(idx_nxt)) && (bcd_q[4*k +: 4] != 4'd0)) begin
                blank = 1'b0;
            end
        end
        if (cnt_q == c_cnt_max) begin
            idx_d = idx_nxt;
            an_d  = ~(DIGITS'(1) << idx_nxt);
            seg_d = blank ? 7'h7F : seg_of(digit);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            shadow_q   <= '0;
            work_q     <= '0;
            acc_q      <= '0;
            bitcnt_q   <= '0;
            ovf_pend_q <= 1'b0;
            bcd_q      <= '0;
            busy_q     <= 1'b0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
            idx_q      <= '0;
            an_q       <= '1;
            seg_q      <= 7'h7F;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            work_q     <= work_d;
            acc_q      <= acc_d;
            bitcnt_q   <= bitcnt_d;
            ovf_pend_q <= ovf_pend_d;
            bcd_q      <= bcd_d;
            busy_q     <= busy_d;
            ovf_q      <= ovf_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign bus.bcd      = bcd_q;
    assign bus.busy     = busy_q;
    assign bus.overflow = ovf_q;
    assign bus.an       = an_q;
    assign bus.seg      = seg_q;
endmodule
`default_nettype wire

// File: tb/tb_score_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_score_display
// Description : Self-checking bench for score_display (two blanking variants).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_score_display;
    localparam int RDIV = 4;

    logic clk;
    logic resetn;
    int   n_chk  = 0;
    int   n_pass = 0;

    score_display_if sif_a ();
    score_display_if sif_b ();
    assign sif_b.score = sif_a.score;

    score_display #(.DIGITS(4), .REFRESH_DIV(RDIV), .BLANK_LZ(1)) u_dut_a (
        .clk(clk), .resetn(resetn), .bus(sif_a)
    );
    score_display #(.DIGITS(4), .REFRESH_DIV(RDIV), .BLANK_LZ(0)) u_dut_b (
        .clk(clk), .resetn(resetn), .bus(sif_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] seg7(input int d);
        case (d)
            0: seg7 = 7'h40;  1: seg7 = 7'h79;  2: seg7 = 7'h24;  3: seg7 = 7'h30;
            4: seg7 = 7'h19;  5: seg7 = 7'h12;  6: seg7 = 7'h02;  7: seg7 = 7'h78;
            8: seg7 = 7'h00;  9: seg7 = 7'h10;  default: seg7 = 7'h7F;
        endcase
    endfunction

    function automatic int pow10(input int k);
        pow10 = (k == 0) ? 1 : (k == 1) ? 10 : (k == 2) ? 100 : 1000;
    endfunction

    // Decimal view of the displayed value: digit k and its leading-zero blanking.
    function automatic logic [6:0] ref_seg(input int v, input int k, input bit blz);
        if (blz && k > 0 && v < pow10(k)) ref_seg = 7'h7F;
        else                              ref_seg = seg7((v / pow10(k)) % 10);
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        to_bcd = {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic [3:0] an_of(input int k);
        logic [3:0] one;
        one    = 4'b0001;
        an_of  = ~(one << k);
    endfunction

    // Reference model: conversion is a 15-edge countdown; display advances every RDIV edges.
    logic [31:0] m_shadow, m_pend;
    int          m_left, m_val, m_edges, m_idx;
    bit          m_ovf;
    logic [3:0]  m_an;
    logic [6:0]  m_seg_a, m_seg_b;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_shadow = 0; m_pend = 0; m_left = 0; m_val = 0; m_ovf = 0;
            m_edges  = 0; m_idx = 0; m_an = 4'hF; m_seg_a = 7'h7F; m_seg_b = 7'h7F;
        end else begin
            m_edges++;
            if (m_edges % RDIV == 0) begin
                m_idx   = (m_idx + 1) % 4;
                m_an    = an_of(m_idx);
                m_seg_a = ref_seg(m_val, m_idx, 1'b1);
                m_seg_b = ref_seg(m_val, m_idx, 1'b0);
            end
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_val = (m_pend > 32'd9999) ? 9999 : int'(m_pend);
                    m_ovf = (m_pend > 32'd9999);
                end
            end else if (sif_a.score != m_shadow) begin
                m_shadow = sif_a.score;
                m_pend   = sif_a.score;
                m_left   = 15;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] score;
        logic [15:0] exp_bcd;
        logic        exp_ovf;
    } vec_t;

    vec_t        vecs[8];
    logic [15:0] prev_bcd;
    logic [31:0] prev_score, nscore;
    int          busy_cnt, k, r;
    bit          found;
    logic [3:0]  an_prev;

    initial begin
        vecs[0] = '{32'd1234,       16'h1234, 1'b0};
        vecs[1] = '{32'd12345,      16'h9999, 1'b1};
        vecs[2] = '{32'd42,         16'h0042, 1'b0};
        vecs[3] = '{32'd10000,      16'h9999, 1'b1};
        vecs[4] = '{32'd9999,       16'h9999, 1'b0};
        vecs[5] = '{32'd0,          16'h0000, 1'b0};
        vecs[6] = '{32'hFFFF_FFFF,  16'h9999, 1'b1};
        vecs[7] = '{32'd7,          16'h0007, 1'b0};

        sif_a.score = 32'd0;
        resetn      = 1'b1;
        #2 resetn   = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;

        // Reset state and first refresh tick.
        busy_cnt = 0;
        for (int i = 1; i <= 3; i++) begin
            step();
            busy_cnt += int'(sif_a.busy);
            chk("rst_an", {28'd0, sif_a.an}, 32'hF);
            chk("rst_seg", {25'd0, sif_a.seg}, 32'h7F);
        end
        step();
        busy_cnt += int'(sif_a.busy);
        chk("tick1_an", {28'd0, sif_a.an}, 32'hD);
        chk("tick1_seg_blank", {25'd0, sif_a.seg}, 32'h7F);
        chk("tick1_seg_noblank", {25'd0, sif_b.seg}, 32'h40);
        for (int i = 0; i < 96; i++) begin
            step();
            busy_cnt += int'(sif_a.busy);
        end
        chk("idle_busy_count", busy_cnt, 0);
        chk("idle_bcd", {16'd0, sif_a.bcd}, 32'h0);
        chk("idle_ovf", {31'd0, sif_a.overflow}, 32'h0);

        // Table-driven conversions with exact latency.
        prev_bcd = 16'h0000;
        for (int v = 0; v < 8; v++) begin
            sif_a.score = vecs[v].score;
            busy_cnt    = 0;
            for (int e = 0; e <= 15; e++) begin
                step();
                busy_cnt += int'(sif_a.busy);
                if (e == 0)  chk($sformatf("v%0d_busy_E0", v), {31'd0, sif_a.busy}, 32'h1);
                if (e == 14) chk($sformatf("v%0d_bcd_E14", v), {16'd0, sif_a.bcd}, {16'd0, prev_bcd});
            end
            chk($sformatf("v%0d_busy_len", v), busy_cnt, 15);
            chk($sformatf("v%0d_bcd", v), {16'd0, sif_a.bcd}, {16'd0, vecs[v].exp_bcd});
            chk($sformatf("v%0d_bcd_b", v), {16'd0, sif_b.bcd}, {16'd0, vecs[v].exp_bcd});
            chk($sformatf("v%0d_ovf", v), {31'd0, sif_a.overflow}, {31'd0, vecs[v].exp_ovf});
            chk($sformatf("v%0d_busy_E15", v), {31'd0, sif_a.busy}, 32'h0);
            prev_bcd = vecs[v].exp_bcd;
        end

        // Digit scan with score 7 displayed.
        an_prev = sif_a.an;
        found   = 1'b0;
        for (int i = 0; i < 2 * RDIV && !found; i++) begin
            step();
            if (sif_a.an != an_prev) found = 1'b1;
        end
        chk("mux_sync", {31'd0, found}, 32'h1);
        k = -1;
        for (int j = 0; j < 4; j++) if (sif_a.an == an_of(j)) k = j;
        chk("mux_onehot", {31'd0, k >= 0}, 32'h1);
        if (k >= 0) begin
            for (int j = 1; j <= 16; j++) begin
                int idx;
                step();
                idx = (k + j / RDIV) % 4;
                chk("mux_an", {28'd0, sif_a.an}, {28'd0, an_of(idx)});
                chk("mux_seg_blank", {25'd0, sif_a.seg}, (idx == 0) ? 32'h78 : 32'h7F);
                chk("mux_seg_noblank", {25'd0, sif_b.seg}, (idx == 0) ? 32'h78 : 32'h40);
            end
        end

        // Score change in the middle of a conversion.
        sif_a.score = 32'd5;
        repeat (4) step();
        sif_a.score = 32'd9;
        repeat (12) step();
        chk("mid_first_bcd", {16'd0, sif_a.bcd}, 32'h0005);
        chk("mid_first_busy", {31'd0, sif_a.busy}, 32'h0);
        step();
        chk("mid_second_start", {31'd0, sif_a.busy}, 32'h1);
        repeat (14) step();
        chk("mid_second_E14", {16'd0, sif_a.bcd}, 32'h0005);
        step();
        chk("mid_second_bcd", {16'd0, sif_a.bcd}, 32'h0009);

        // A transient value that returns to the captured score is never converted.
        sif_a.score = 32'd3;
        repeat (2) step();
        sif_a.score = 32'd4;
        repeat (3) step();
        sif_a.score = 32'd3;
        repeat (11) step();
        chk("revert_bcd", {16'd0, sif_a.bcd}, 32'h0003);
        busy_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            busy_cnt += int'(sif_a.busy);
        end
        chk("revert_no_busy", busy_cnt, 0);

        // Reset in the middle of a conversion.
        sif_a.score = 32'd88;
        repeat (8) step();
        chk("abort_busy_E7", {31'd0, sif_a.busy}, 32'h1);
        resetn = 1'b0;
        #1;
        chk("abort_bcd", {16'd0, sif_a.bcd}, 32'h0);
        chk("abort_busy", {31'd0, sif_a.busy}, 32'h0);
        chk("abort_an", {28'd0, sif_a.an}, 32'hF);
        chk("abort_seg", {25'd0, sif_a.seg}, 32'h7F);
        step();
        resetn = 1'b1;
        step();
        chk("restart_busy", {31'd0, sif_a.busy}, 32'h1);
        repeat (15) step();
        chk("restart_bcd", {16'd0, sif_a.bcd}, 32'h0088);
        chk("restart_busy_end", {31'd0, sif_a.busy}, 32'h0);

        // Randomized run against the reference model.
        prev_score = sif_a.score;
        for (int i = 0; i < 600; i++) begin
            step();
            chk("rand_a", {3'd0, sif_a.bcd, sif_a.busy, sif_a.overflow, sif_a.an, sif_a.seg},
                {3'd0, to_bcd(m_val), m_left > 0, m_ovf, m_an, m_seg_a});
            chk("rand_seg_b", {25'd0, sif_b.seg}, {25'd0, m_seg_b});
            r = int'($urandom_range(0, 15));
            nscore = sif_a.score;
            case (r)
                0, 1: nscore = $urandom_range(0, 9999);
                2:    nscore = $urandom;
                3:    nscore = prev_score;
                4:    nscore = ($urandom_range(0, 1) == 0) ? 32'd9999 : 32'd10000;
                5:    nscore = $urandom_range(0, 120);
                default: ;
            endcase
            if (nscore != sif_a.score) prev_score = sif_a.score;
            sif_a.score = nscore;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
